systolic_job_ctrl: RTL and testbench
====================================

SYSTOLIC_JOB_CTRL -- requirements
Module: systolic_job_ctrl

Interface
REQ-001 SHALL have parameters: N, default 8, array dimension; DATA_WIDTH, default 32, operand width; TIMEOUT_CYCLES, default 4096, compute-plus-drain watchdog limit.
REQ-002 SHALL have ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- job_valid_i  in  1  job request.
- job_ready_o  out  1  job accepted when both are high.
- abort_i  in  1  cancel the current job.
- load_valid_i  in  1  operand word valid.
- load_data_i  in  DATA_WIDTH  operand word.
- load_ready_o  out  1  operand word accepted when both are high.
- north_write_enable_o  out  1  North queue write strobe.
- north_write_data_o  out  DATA_WIDTH  North queue write data.
- north_write_reset_o  out  1  North queue pointer reset.
- west_write_enable_o, west_write_data_o, west_write_reset_o  out  1/DATA_WIDTH/1  same three signals for the West queue.
- start_matrix_mult_o  out  1  array start pulse.
- matrix_mult_complete_i  in  1  array done level.
- accumulator_drain_complete_i  in  1  drain done level.
- busy_o  out  1  high in any state except IDLE.
- job_done_o  out  1  one-cycle end-of-job pulse.
- job_error_o  out  1  qualifies job_done_o; high means timeout.
- job_count_o  out  16  count of successful jobs.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, LOAD_N, LOAD_W, START, COMPUTE, DRAIN, DONE.
REQ-004 IDLE: job_ready_o=1; a handshake moves to CLEAR. job_ready_o SHALL be 0 in every other state.
REQ-005 CLEAR: north_write_reset_o=west_write_reset_o=1 for exactly 1 cycle, then LOAD_N.
REQ-006 LOAD_N/LOAD_W: load_ready_o = 1 & !abort_i. Each accepted word SHALL appear on the matching write_data_o with write_enable_o=1 on the next cycle (registered, latency 1).
REQ-007 Word counter width clog2(N*N) SHALL count accepted words 0..N*N-1 and clear on state exit. LOAD_N SHALL accept exactly N*N words, then LOAD_W SHALL accept exactly N*N words, then go to START. Gaps with load_valid_i=0 SHALL stall without a timeout.
REQ-008 START: start_matrix_mult_o=1 for exactly 1 cycle, issued no earlier than the cycle after the last west write strobe; then COMPUTE.
REQ-009 COMPUTE: wait for matrix_mult_complete_i=1, then DRAIN.
REQ-010 DRAIN SHALL advance only on a rising edge of accumulator_drain_complete_i (current=1, previous-cycle registered=0), so a stale high level from the previous job is ignored; then DONE.
REQ-011 Watchdog SHALL clear on entry to COMPUTE and increment each cycle in COMPUTE/DRAIN. Reaching TIMEOUT_CYCLES SHALL go to DONE with the error flag set.
REQ-012 DONE: job_done_o=1 for 1 cycle, with job_error_o=error flag in the same cycle; then IDLE. job_error_o SHALL be 0 whenever job_done_o=0.
REQ-013 job_count_o SHALL increment on error-free DONE only and wrap 0xFFFF->0x0000.
REQ-014 abort_i in any non-IDLE, non-DONE state SHALL go to CLEAR-equivalent cleanup: one cycle of both write_reset_o, then IDLE. No job_done_o pulse and no count change.
REQ-015 Simultaneous events: abort_i beats complete/drain/timeout/last load word. Timeout and qualifying completion in the same cycle SHALL be treated as success. job_valid_i outside IDLE SHALL be ignored.
REQ-016 All outputs SHALL be registered except job_ready_o, load_ready_o and busy_o, which are decoded from state.

Reset
REQ-017 rst_i high SHALL force IDLE asynchronously, regardless of state, including mid-load or mid-compute.
REQ-018 Reset values SHALL be 0 for all write strobes, write resets, write data, start_matrix_mult_o, job_done_o, job_error_o, job_count_o, word counter, watchdog, drain-edge register and error flag.
REQ-019 Reset values of the decoded outputs SHALL be job_ready_o=1, load_ready_o=0, busy_o=0.

Structure
REQ-020 Package systolic_pkg SHALL hold the ctrl_state_e enum typedef (binary encoding) and the JOB_COUNT_W=16 constant.
REQ-021 The watchdog SHALL be a sub-module systolic_watchdog (clear, enable, limit, expired).
REQ-022 The block SHALL connect directly to the array's north/west write ports, start_matrix_mult_i, matrix_mult_complete_o and accumulator_drain_complete_o.

Verification (N=2, TIMEOUT_CYCLES=64)
REQ-023 Nominal job: job handshake, load words 1..8 back-to-back, complete at +10 cycles, drain edge at +3 -> resets 1 cycle; north writes 1,2,3,4; west writes 5,6,7,8; single start pulse; job_done_o=1, job_error_o=0, job_count_o=1.
REQ-024 Stale drain: drain_complete held 1 from a prior job through entry to DRAIN, falls, rises 4 cycles later -> job_done_o only after the new rising edge.
REQ-025 Timeout: complete never asserted -> job_done_o=1, job_error_o=1 exactly 64 cycles after COMPUTE entry; job_count_o unchanged.
REQ-026 Abort during LOAD_W after 2 words, with load_valid_i=1 -> load_ready_o=0 that cycle, one reset pulse, IDLE, no done, no further write strobes.
REQ-027 Irregular load: load_valid_i toggled 1/0 for 16 cycles -> exactly 8 write strobes in order, and start only after the 8th.
REQ-028 rst_i asserted in COMPUTE -> all outputs at reset values asynchronously; a new job after release completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array job controller.
//   ctrl_state_e : controller FSM state (binary encoded)
//   JOB_COUNT_W  : width of the successful-job counter
//   cnt_width()  : counter width able to index n values (minimum 1 bit)
package systolic_pkg;

    localparam int unsigned JOB_COUNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD_N  = 3'd2,
        LOAD_W  = 3'd3,
        START   = 3'd4,
        COMPUTE = 3'd5,
        DRAIN   = 3'd6,
        DONE    = 3'd7
    } ctrl_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/systolic_watchdog.sv
// Cycle watchdog for the compute and drain phases.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (held while the job is being started)
//   enable   : count this cycle
//   limit    : number of enabled cycles allowed
//   expired  : high in the last allowed enabled cycle
module systolic_watchdog #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    localparam int unsigned EW = WIDTH + 1;

    logic [WIDTH-1:0] count;

    // Saturating cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    // Flag the cycle that would bring the count up to the limit
    assign expired = enable && ((EW'(count) + EW'(1)) >= EW'(limit));

endmodule

// File: rtl/systolic_job_ctrl.sv
// Job controller for an N x N systolic array: clears the operand queues,
// streams N*N North words then N*N West words, pulses start, waits for
// completion and a fresh drain edge, and reports done/error per job.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   job_valid_i / job_ready_o    : job request handshake
//   abort_i                      : cancel the job in flight
//   load_valid_i/_data_i/_ready_o: operand word stream
//   north_write_*, west_write_*  : queue write strobe, data, pointer reset
//   start_matrix_mult_o          : array start pulse
//   matrix_mult_complete_i       : array done level
//   accumulator_drain_complete_i : drain done level
//   busy_o, job_done_o, job_error_o, job_count_o : status
module systolic_job_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N              = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic                   abort_i,
    input  logic                   load_valid_i,
    input  logic [DATA_WIDTH-1:0]  load_data_i,
    output logic                   load_ready_o,
    output logic                   north_write_enable_o,
    output logic [DATA_WIDTH-1:0]  north_write_data_o,
    output logic                   north_write_reset_o,
    output logic                   west_write_enable_o,
    output logic [DATA_WIDTH-1:0]  west_write_data_o,
    output logic                   west_write_reset_o,
    output logic                   start_matrix_mult_o,
    input  logic                   matrix_mult_complete_i,
    input  logic                   accumulator_drain_complete_i,
    output logic                   busy_o,
    output logic                   job_done_o,
    output logic                   job_error_o,
    output logic [JOB_COUNT_W-1:0] job_count_o
);

    localparam int unsigned WORDS  = N * N;
    localparam int unsigned WCNT_W = cnt_width(WORDS);
    localparam int unsigned WD_W   = cnt_width(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

    ctrl_state_e       state;
    ctrl_state_e       next_state;
    logic [WCNT_W-1:0] word_cnt;
    logic              drain_prev;

    logic load_phase, accept, last_word, abort_hit, drain_edge;
    logic wd_clear, wd_enable, wd_expired, timeout_hit;
    logic north_we_d, west_we_d, wreset_d, start_d, done_d, error_d;

    // Decoded handshake/status outputs
    assign load_phase   = (state == LOAD_N) || (state == LOAD_W);
    assign load_ready_o = load_phase && !abort_i;
    assign job_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);

    assign accept     = load_valid_i && load_ready_o;
    assign last_word  = (word_cnt == LAST_WORD);
    assign abort_hit  = abort_i && (state != IDLE) && (state != DONE);
    // A level left high by the previous job must not end this one
    assign drain_edge = accumulator_drain_complete_i && !drain_prev;

    systolic_watchdog #(
        .WIDTH(WD_W)
    ) u_watchdog (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (wd_clear),
        .enable (wd_enable),
        .limit  (WD_W'(TIMEOUT_CYCLES)),
        .expired(wd_expired)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state; completion is checked before the watchdog so a tie succeeds
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        if (abort_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (job_valid_i) next_state = CLEAR;
                CLEAR:   next_state = LOAD_N;
                LOAD_N:  if (accept && last_word) next_state = LOAD_W;
                LOAD_W:  if (accept && last_word) next_state = START;
                START:   next_state = COMPUTE;
                COMPUTE: begin
                    if (matrix_mult_complete_i) begin
                        next_state = DRAIN;
                    end else if (wd_expired) begin
                        next_state  = DONE;
                        timeout_hit = 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_edge) begin
                        next_state = DONE;
                    end else if (wd_expired) begin
                        next_state  = DONE;
                        timeout_hit = 1'b1;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        north_we_d = accept && (state == LOAD_N);
        west_we_d  = accept && (state == LOAD_W);
        wreset_d   = abort_hit || (next_state == CLEAR);
        start_d    = (state == START) && !abort_i;
        done_d     = (next_state == DONE);
        error_d    = timeout_hit;
        wd_clear   = (state == START);
        wd_enable  = (state == COMPUTE) || (state == DRAIN);
    end

    // Registered outputs and datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            north_write_enable_o <= 1'b0;
            north_write_data_o   <= '0;
            north_write_reset_o  <= 1'b0;
            west_write_enable_o  <= 1'b0;
            west_write_data_o    <= '0;
            west_write_reset_o   <= 1'b0;
            start_matrix_mult_o  <= 1'b0;
            job_done_o           <= 1'b0;
            job_error_o          <= 1'b0;
            job_count_o          <= '0;
            word_cnt             <= '0;
            drain_prev           <= 1'b0;
        end else begin
            north_write_enable_o <= north_we_d;
            west_write_enable_o  <= west_we_d;
            if (north_we_d) north_write_data_o <= load_data_i;
            if (west_we_d)  west_write_data_o  <= load_data_i;
            north_write_reset_o  <= wreset_d;
            west_write_reset_o   <= wreset_d;
            start_matrix_mult_o  <= start_d;
            job_done_o           <= done_d;
            job_error_o          <= error_d;
            if (done_d && !error_d) job_count_o <= job_count_o + JOB_COUNT_W'(1);
            if (next_state != state) begin
                word_cnt <= '0;
            end else if (accept) begin
                word_cnt <= word_cnt + WCNT_W'(1);
            end
            drain_prev <= accumulator_drain_complete_i;
        end
    end

endmodule

// File: tb/tb_systolic_job_ctrl.sv
module tb_systolic_job_ctrl;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 64;
    localparam int WPQ = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0, abort = 1'b0, load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          mm_complete = 1'b0, drain_complete = 1'b0;

    logic          job_ready, load_ready, busy, job_done, job_error, start_pulse;
    logic          north_we, north_rst, west_we, west_rst;
    logic [DW-1:0] north_data, west_data;
    logic [15:0]   job_count;

    systolic_job_ctrl #(.N(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .job_valid_i                 (job_valid),
        .job_ready_o                 (job_ready),
        .abort_i                     (abort),
        .load_valid_i                (load_valid),
        .load_data_i                 (load_data),
        .load_ready_o                (load_ready),
        .north_write_enable_o        (north_we),
        .north_write_data_o          (north_data),
        .north_write_reset_o         (north_rst),
        .west_write_enable_o         (west_we),
        .west_write_data_o           (west_data),
        .west_write_reset_o          (west_rst),
        .start_matrix_mult_o         (start_pulse),
        .matrix_mult_complete_i      (mm_complete),
        .accumulator_drain_complete_i(drain_complete),
        .busy_o                      (busy),
        .job_done_o                  (job_done),
        .job_error_o                 (job_error),
        .job_count_o                 (job_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Job-level model: phase of the job, words taken, cycles spent on the array
    typedef enum int {P_IDLE, P_CLR, P_LOAD, P_KICK, P_ARR, P_DRN, P_END} phase_t;
    phase_t        ph = P_IDLE;
    int            nwords = 0, elapsed = 0;
    logic          drain_last = 1'b0, abt = 1'b0, take = 1'b0;
    logic          e_nwe = 1'b0, e_wwe = 1'b0, e_rst = 1'b0, e_start = 1'b0;
    logic          e_done = 1'b0, e_err = 1'b0;
    logic [DW-1:0] e_nwd = '0, e_wwd = '0;
    logic [15:0]   e_count = '0;

    task model_finish(input logic err);
        ph = P_END;
        e_done = 1'b1;
        e_err = err;
        if (!err) e_count = e_count + 16'd1;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            ph = P_IDLE; nwords = 0; elapsed = 0; drain_last = 1'b0;
            e_nwe = 1'b0; e_wwe = 1'b0; e_nwd = '0; e_wwd = '0; e_rst = 1'b0;
            e_start = 1'b0; e_done = 1'b0; e_err = 1'b0; e_count = '0;
        end else begin
            abt  = abort && (ph != P_IDLE) && (ph != P_END);
            take = (ph == P_LOAD) && load_valid && !abort;
            e_nwe = take && (nwords < WPQ);
            e_wwe = take && (nwords >= WPQ);
            if (e_nwe) e_nwd = load_data;
            if (e_wwe) e_wwd = load_data;
            e_start = (ph == P_KICK) && !abort;
            e_rst = 1'b0; e_done = 1'b0; e_err = 1'b0;
            if (abt) begin
                ph = P_IDLE;
                e_rst = 1'b1;
            end else begin
                case (ph)
                    P_IDLE: if (job_valid) begin ph = P_CLR; e_rst = 1'b1; end
                    P_CLR:  begin ph = P_LOAD; nwords = 0; end
                    P_LOAD: if (take) begin
                        nwords++;
                        if (nwords == 2 * WPQ) ph = P_KICK;
                    end
                    P_KICK: begin ph = P_ARR; elapsed = 0; end
                    P_ARR: begin
                        if (mm_complete) ph = P_DRN;
                        else if (elapsed + 1 >= int'(TO)) model_finish(1'b1);
                        elapsed++;
                    end
                    P_DRN: begin
                        if (drain_complete && !drain_last) model_finish(1'b0);
                        else if (elapsed + 1 >= int'(TO)) model_finish(1'b1);
                        elapsed++;
                    end
                    default: ph = P_IDLE;
                endcase
            end
            drain_last = drain_complete;
        end
    end

    // Event logs read by the scenario checks
    logic [31:0] nq[$], wq[$], derr[$];
    int          wcyc[$], scyc[$], dcycq[$];
    int          rst_pulses = 0;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("job_ready",   32'(job_ready),   32'(ph == P_IDLE));
        chk("load_ready",  32'(load_ready),  32'((ph == P_LOAD) && !abort));
        chk("busy",        32'(busy),        32'(ph != P_IDLE));
        chk("north_we",    32'(north_we),    32'(e_nwe));
        chk("north_data",  north_data,       e_nwd);
        chk("west_we",     32'(west_we),     32'(e_wwe));
        chk("west_data",   west_data,        e_wwd);
        chk("north_reset", 32'(north_rst),   32'(e_rst));
        chk("west_reset",  32'(west_rst),    32'(e_rst));
        chk("start",       32'(start_pulse), 32'(e_start));
        chk("job_done",    32'(job_done),    32'(e_done));
        chk("job_error",   32'(job_error),   32'(e_err));
        chk("job_count",   32'(job_count),   32'(e_count));
        if (north_we) nq.push_back(north_data);
        if (west_we) begin wq.push_back(west_data); wcyc.push_back(cyc); end
        if (start_pulse) scyc.push_back(cyc);
        if (job_done) begin dcycq.push_back(cyc); derr.push_back(32'(job_error)); end
        if (north_rst) rst_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        nq.delete(); wq.delete(); derr.delete();
        wcyc.delete(); scyc.delete(); dcycq.delete();
        rst_pulses = 0;
    endtask

    task automatic start_job();
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
    endtask

    task automatic load(input int first, input int count, input bit gappy);
        int idx = 0;
        int n = 0;
        while (idx < count && n < 100) begin
            load_valid = gappy ? n[0] : 1'b1;
            load_data  = 32'(first + idx);
            @(negedge clk);
            if (load_valid && load_ready) idx++;
            step();
            n++;
        end
        load_valid = 1'b0;
        chk("load_words", 32'(idx), 32'(count));
    endtask

    task automatic wait_start();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = start_pulse;
            step();
        end
        chk("start_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget && dc < 0; i++) begin
            @(negedge clk);
            if (job_done) dc = cyc;
            step();
        end
        chk("done_seen", 32'(dc >= 0), 32'd1);
    endtask

    task automatic check_words(input string name, input int nbase, input int wbase);
        chk({name, "_north_n"}, 32'(nq.size()), 32'(WPQ));
        chk({name, "_west_n"},  32'(wq.size()), 32'(WPQ));
        for (int i = 0; i < WPQ; i++) begin
            chk({name, "_north_word"}, (i < nq.size()) ? nq[i] : 32'hdead, 32'(nbase + i));
            chk({name, "_west_word"},  (i < wq.size()) ? wq[i] : 32'hdead, 32'(wbase + i));
        end
    endtask

    int dc, rise;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready",  32'(job_ready),  32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_count",      32'(job_count),  32'd0);
        rst = 1'b0;
        step();

        // Nominal job
        clear_logs();
        start_job();
        load(1, 8, 1'b0);
        wait_start();
        repeat (8) step();
        mm_complete = 1'b1;
        repeat (3) step();
        drain_complete = 1'b1;
        wait_done(20, dc);
        mm_complete = 1'b0;
        check_words("nominal", 1, 5);
        chk("nominal_starts", 32'(scyc.size()), 32'd1);
        chk("nominal_resets", 32'(rst_pulses), 32'd1);
        chk("nominal_err",    (derr.size() > 0) ? derr[0] : 32'hdead, 32'd0);
        chk("nominal_count",  32'(job_count), 32'd1);

        // Stale drain level must be ignored until a fresh rising edge
        clear_logs();
        start_job();
        load(11, 8, 1'b0);
        wait_start();
        step();
        mm_complete = 1'b1;
        repeat (4) step();
        mm_complete = 1'b0;
        drain_complete = 1'b0;
        repeat (4) step();
        chk("stale_no_early_done", 32'(dcycq.size()), 32'd0);
        drain_complete = 1'b1;
        rise = cyc;
        wait_done(20, dc);
        chk("stale_done_cycle", 32'(dc), 32'(rise + 1));
        chk("stale_count",      32'(job_count), 32'd2);

        // Timeout
        drain_complete = 1'b0;
        clear_logs();
        start_job();
        load(21, 8, 1'b0);
        wait_done(120, dc);
        chk("timeout_err", (derr.size() > 0) ? derr[0] : 32'hdead, 32'd1);
        chk("timeout_latency", 32'(dc - ((scyc.size() > 0) ? scyc[0] : 0)), 32'd64);
        chk("timeout_count", 32'(job_count), 32'd2);

        // Abort during the West load after two words
        clear_logs();
        start_job();
        load(31, 6, 1'b0);
        abort = 1'b1;
        load_valid = 1'b1;
        load_data = 32'd37;
        @(negedge clk);
        chk("abort_load_ready", 32'(load_ready), 32'd0);
        step();
        abort = 1'b0;
        load_valid = 1'b0;
        repeat (6) step();
        chk("abort_west_n",  32'(wq.size()),    32'd2);
        chk("abort_north_n", 32'(nq.size()),    32'd4);
        chk("abort_no_done", 32'(dcycq.size()), 32'd0);
        chk("abort_resets",  32'(rst_pulses),   32'd2);
        chk("abort_count",   32'(job_count),    32'd2);
        chk("abort_idle",    32'(job_ready),    32'd1);

        // Irregular load stream
        clear_logs();
        start_job();
        load(41, 8, 1'b1);
        wait_start();
        step();
        mm_complete = 1'b1;
        repeat (2) step();
        drain_complete = 1'b1;
        wait_done(20, dc);
        mm_complete = 1'b0;
        drain_complete = 1'b0;
        check_words("irregular", 41, 45);
        chk("irregular_start_after_west",
            32'(((scyc.size() > 0) ? scyc[0] : 0) > ((wcyc.size() > 3) ? wcyc[3] : 1 << 30)), 32'd1);
        chk("irregular_count", 32'(job_count), 32'd3);

        // Asynchronous reset while computing, then a clean job
        clear_logs();
        start_job();
        load(51, 8, 1'b0);
        wait_start();
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",      32'(busy),        32'd0);
        chk("arst_job_ready", 32'(job_ready),   32'd1);
        chk("arst_start",     32'(start_pulse), 32'd0);
        chk("arst_data",      north_data,       32'd0);
        chk("arst_count",     32'(job_count),   32'd0);
        step();
        rst = 1'b0;
        step();
        clear_logs();
        start_job();
        load(61, 8, 1'b0);
        wait_start();
        step();
        mm_complete = 1'b1;
        repeat (2) step();
        drain_complete = 1'b1;
        wait_done(20, dc);
        check_words("post_reset", 61, 65);
        chk("post_reset_err",   (derr.size() > 0) ? derr[0] : 32'hdead, 32'd0);
        chk("post_reset_count", 32'(job_count), 32'd1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
